llc_cmd_sequencer: RTL
======================

Name: llc_cmd_sequencer

Overview:
Sits between the trace parser and the LLC tag/state array. Accepts parsed trace commands (operation, 32-bit address) over a valid/ready interface and buffers them in a small FIFO. Decodes each address into tag/index/offset and issues one request at a time to the cache array with a req/ack handshake. Expands clear (op 8) and print (op 9) into full-set sweeps, and keeps hit/miss/access statistics.

Parameters:
ADDR_W, 32, trace address width
INDEX_W, 14, set index bits (SETS = 2**INDEX_W)
OFFSET_W, 6, byte offset bits (64 B line)
FIFO_DEPTH, 4, command FIFO entries (power of 2, at least 2)
CNT_W, 32, statistics counter width

Ports:
clk  in  1  clock, all state rising-edge
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  parser presents a command
cmd_ready  out  1  FIFO can accept (= !full)
cmd_op  in  4  trace operation code 0-9
cmd_addr  in  ADDR_W  trace address
cache_req  out  1  request to cache array
cache_ack  in  1  array completed request (one-cycle pulse)
cache_hit  in  1  lookup result, sampled only with cache_ack
cache_op  out  4  operation issued (same encoding as cmd_op)
cache_tag  out  ADDR_W-INDEX_W-OFFSET_W  address tag
cache_index  out  INDEX_W  set index
busy  out  1  FIFO non-empty or FSM not IDLE
reads_cnt  out  CNT_W  ops 0 and 2 completed
writes_cnt  out  CNT_W  op 1 completed
hits_cnt  out  CNT_W  ops 0/1/2 acked with cache_hit=1
misses_cnt  out  CNT_W  ops 0/1/2 acked with cache_hit=0
bad_cmd_cnt  out  CNT_W  commands with op 7 or op greater than 9

Behaviour:
- Reset (async, any time): FIFO emptied, FSM to IDLE, and all outputs 0 except cmd_ready=1. An in-flight cache_req drops immediately, and a later ack for it is ignored.
- FIFO push: when cmd_valid && cmd_ready, {op, addr} is written. Full: cmd_ready=0 and no push, even when a pop occurs in the same cycle. Pointers wrap mod FIFO_DEPTH. Push and pop in the same cycle are legal when not full.
- Address split: tag = addr[ADDR_W-1 : INDEX_W+OFFSET_W], index = addr[INDEX_W+OFFSET_W-1 : OFFSET_W]. The offset is discarded.
- FSM states:
  - IDLE: if the FIFO is non-empty, examine the head entry.
    - ops 0-6: load cache_op, cache_tag and cache_index, assert cache_req next cycle, go to ISSUE.
    - op 8: zero all stat counters except bad_cmd_cnt, set sweep index 0, go to SWEEP.
    - op 9: set sweep index 0, go to SWEEP.
    - op 7 or op greater than 9: pop, increment bad_cmd_cnt, stay IDLE. No cache traffic.
  - ISSUE: cache_req=1, with op/tag/index held stable until cache_ack. On ack:
    - deassert req in the same edge and pop the FIFO;
    - update stats (ops 0/2: reads+1; op 1: writes+1; ops 0/1/2: hits or misses +1; ops 3-6: no stat change);
    - return to IDLE.
    - Minimum spacing between consecutive requests is 1 idle cycle.
  - SWEEP: cache_req=1, cache_op = head op (8 or 9), cache_tag=0, cache_index=sweep index.
    - On each ack, sweep index +1, and req stays high for the next set.
    - On the ack at index SETS-1: pop, req=0, go to IDLE.
    - Exactly SETS acks are consumed per sweep.
- cache_ack while cache_req=0 is ignored. cache_hit is ignored outside ISSUE with ops 0-2.
- Counters saturate at all-ones, with no wrap.
- busy = (FIFO count != 0) || (state != IDLE).

Decomposition:
- Shared package llc_pkg:
  - op enum (OP_RD_D=0, OP_WR_D=1, OP_RD_I=2, OP_SN_RD=3, OP_SN_WR=4, OP_SN_RWIM=5, OP_SN_INV=6, OP_CLR=8, OP_PRINT=9);
  - address-field width constants;
  - FSM state enum.
- One sub-module, llc_cmd_fifo: a parameterized sync FIFO with full/empty/count, holding {op, addr}.

Test Plan:
- Reset release, push op 0 at addr 32'h1234_5678, ack with hit=0 after 3 cycles:
  - cache_index=14'h1159, cache_tag=12'h123;
  - reads_cnt=1, misses_cnt=1, busy=0 afterwards.
- Push 5 commands back-to-back while ack is withheld:
  - cmd_ready=0 after 4 accepted;
  - 5th accepted on the cycle after the first ack.
- Push op 1 and ack with hit=1, then push op 8 and ack SETS times:
  - 16384 requests with index 0..16383 in order;
  - writes_cnt and hits_cnt=0 after the sweep starts.
- Push ops 7 and 12, then op 3:
  - bad_cmd_cnt=2, no cache_req for the bad ops;
  - op 3 issued with stats unchanged after its ack.
- Assert rst for 1 cycle mid-ISSUE with a pending FIFO of 3 entries:
  - cache_req low asynchronously, busy=0, counters 0;
  - a late ack is ignored.
- Drive stats to saturation (force reads_cnt to all-ones), complete one more op 0:
  - reads_cnt stays 32'hFFFF_FFFF.

Source files
------------

// File: rtl/llc_pkg.sv
// llc_pkg: shared definitions for the LLC command sequencer.
//   - trace operation encoding (op_e)
//   - default address field widths for a 64 B line, 16K-set LLC
//   - sequencer FSM state constants
//   - small op classification helpers
package llc_pkg;

    localparam int LLC_ADDR_W   = 32;
    localparam int LLC_INDEX_W  = 14;
    localparam int LLC_OFFSET_W = 6;
    localparam int LLC_TAG_W    = LLC_ADDR_W - LLC_INDEX_W - LLC_OFFSET_W;
    localparam int LLC_OP_W     = 4;

    typedef enum logic [LLC_OP_W-1:0] {
        OP_RD_D    = 4'd0,
        OP_WR_D    = 4'd1,
        OP_RD_I    = 4'd2,
        OP_SN_RD   = 4'd3,
        OP_SN_WR   = 4'd4,
        OP_SN_RWIM = 4'd5,
        OP_SN_INV  = 4'd6,
        OP_CLR     = 4'd8,
        OP_PRINT   = 4'd9
    } op_e;

    // FSM state encoding kept as plain constants so existing tooling that
    // decodes the state register keeps working.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_SWEEP = 2'd2;

    // Op 7 and anything above 9 have no defined meaning in the trace format.
    function automatic logic is_bad_op(input logic [LLC_OP_W-1:0] op);
        return (op == 4'd7) || (op > 4'd9);
    endfunction

    function automatic logic is_sweep_op(input logic [LLC_OP_W-1:0] op);
        return (op == OP_CLR) || (op == OP_PRINT);
    endfunction

endpackage

// File: rtl/llc_cmd_fifo.sv
// llc_cmd_fifo: synchronous FIFO holding packed {op, addr} trace commands.
//   clk, rst       clock / async active-high reset
//   push, wdata    write request (ignored while full)
//   pop,  rdata    read request (ignored while empty); rdata shows the head
//   full, empty    occupancy flags
//   count          number of stored entries, 0..DEPTH
module llc_cmd_fifo #(
    parameter int DATA_W = 36,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: the storage array has no reset; only the pointers and count
    // define validity, so clearing the data would just cost flops.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/llc_cmd_sequencer.sv
// llc_cmd_sequencer: buffers parsed trace commands and issues them one at a
// time to the LLC tag/state array, expanding clear/print into full-set
// sweeps and keeping access statistics.
//   clk, rst                       clock / async active-high reset
//   cmd_valid/ready/op/addr        command input (valid/ready)
//   cache_req/ack/hit              request handshake to the array
//   cache_op/tag/index             request payload, stable while cache_req=1
//   busy                           work pending or in progress
//   reads/writes/hits/misses_cnt   saturating access statistics
//   bad_cmd_cnt                    saturating count of undefined ops
module llc_cmd_sequencer
    import llc_pkg::*;
#(
    parameter int ADDR_W     = LLC_ADDR_W,
    parameter int INDEX_W    = LLC_INDEX_W,
    parameter int OFFSET_W   = LLC_OFFSET_W,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [3:0]                     cmd_op,
    input  logic [ADDR_W-1:0]              cmd_addr,
    output logic                           cache_req,
    input  logic                           cache_ack,
    input  logic                           cache_hit,
    output logic [3:0]                     cache_op,
    output logic [ADDR_W-INDEX_W-OFFSET_W-1:0] cache_tag,
    output logic [INDEX_W-1:0]             cache_index,
    output logic                           busy,
    output logic [CNT_W-1:0]               reads_cnt,
    output logic [CNT_W-1:0]               writes_cnt,
    output logic [CNT_W-1:0]               hits_cnt,
    output logic [CNT_W-1:0]               misses_cnt,
    output logic [CNT_W-1:0]               bad_cmd_cnt
);

    localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W;
    localparam int ENTRY_W = 4 + ADDR_W;

    logic [1:0]                   state;
    logic [ENTRY_W-1:0]           fifo_rdata;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         fifo_pop;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;
    logic [3:0]                   head_op;
    logic [ADDR_W-1:0]            head_addr;
    logic                         acked;
    logic                         unused_offset;

    assign head_op       = fifo_rdata[ENTRY_W-1 -: 4];
    assign head_addr     = fifo_rdata[ADDR_W-1:0];
    assign unused_offset = ^head_addr[OFFSET_W-1:0];
    assign cmd_ready     = !fifo_full;
    assign busy          = (fifo_count != '0) || (state != ST_IDLE);
    // An ack with no request outstanding (e.g. one left over from before a
    // reset) must not advance anything.
    assign acked         = cache_ack && cache_req;

    llc_cmd_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && cmd_ready),
        .wdata ({cmd_op, cmd_addr}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // The head entry stays in the FIFO for the whole transaction and is
    // popped on its final ack; bad ops are dropped straight from IDLE.
    always_comb begin
        fifo_pop = 1'b0;
        case (state)
            ST_IDLE:  fifo_pop = !fifo_empty && is_bad_op(head_op);
            ST_ISSUE: fifo_pop = acked;
            ST_SWEEP: fifo_pop = acked && (&cache_index);
            default:  fifo_pop = 1'b0;
        endcase
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // NOTE: all state here is sequential and uses non-blocking assignments
    // so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cache_req   <= 1'b0;
            cache_op    <= '0;
            cache_tag   <= '0;
            cache_index <= '0;
            reads_cnt   <= '0;
            writes_cnt  <= '0;
            hits_cnt    <= '0;
            misses_cnt  <= '0;
            bad_cmd_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        if (is_bad_op(head_op)) begin
                            bad_cmd_cnt <= sat_inc(bad_cmd_cnt);
                        end else if (is_sweep_op(head_op)) begin
                            if (head_op == OP_CLR) begin
                                reads_cnt  <= '0;
                                writes_cnt <= '0;
                                hits_cnt   <= '0;
                                misses_cnt <= '0;
                            end
                            // cache_index doubles as the sweep index.
                            cache_op    <= head_op;
                            cache_tag   <= '0;
                            cache_index <= '0;
                            cache_req   <= 1'b1;
                            state       <= ST_SWEEP;
                        end else begin
                            cache_op    <= head_op;
                            cache_tag   <= head_addr[ADDR_W-1 -: TAG_W];
                            cache_index <= head_addr[OFFSET_W +: INDEX_W];
                            cache_req   <= 1'b1;
                            state       <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (acked) begin
                        cache_req <= 1'b0;
                        state     <= ST_IDLE;
                        if (cache_op == OP_RD_D || cache_op == OP_RD_I) begin
                            reads_cnt <= sat_inc(reads_cnt);
                        end
                        if (cache_op == OP_WR_D) begin
                            writes_cnt <= sat_inc(writes_cnt);
                        end
                        if (cache_op <= OP_RD_I) begin
                            if (cache_hit) begin
                                hits_cnt <= sat_inc(hits_cnt);
                            end else begin
                                misses_cnt <= sat_inc(misses_cnt);
                            end
                        end
                    end
                end

                ST_SWEEP: begin
                    if (acked) begin
                        if (&cache_index) begin
                            cache_req   <= 1'b0;
                            cache_index <= '0;
                            state       <= ST_IDLE;
                        end else begin
                            cache_index <= cache_index + 1'b1;
                        end
                    end
                end

                default: begin
                    cache_req <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
